// File: rtl/extended_hamming_scrubber.sv
// Background scrubber for an extended-Hamming-protected memory. Walks every
// address at a programmable pace, re-checks each data+code word, writes back
// corrected single-bit errors and records double-bit errors. The memory port
// is shared with the functional path through a request/grant handshake.
//
// Handshake: memory_request is raised together with a stable memory_write,
// memory_address, memory_write_data and memory_write_code; all of them hold
// until a cycle in which memory_grant is high, and the access completes at
// that clock edge. Read data/code arrive one cycle after the granted edge.

`ifndef GET_EXTENDED_HAMMING_PARITY_WIDTH
`define GET_EXTENDED_HAMMING_PARITY_WIDTH(w) (((w) <= 1) ? 3 : ((w) <= 4) ? 4 : ((w) <= 11) ? 5 : ((w) <= 26) ? 6 : ((w) <= 57) ? 7 : ((w) <= 120) ? 8 : 9)
`endif

module extended_hamming_scrubber #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int SCRUB_PERIOD = 64,
    parameter int COUNT_WIDTH = 8,
    localparam int ADDRESS_WIDTH = $clog2(DEPTH),
    localparam int PARITY_WIDTH = `GET_EXTENDED_HAMMING_PARITY_WIDTH(DATA_WIDTH)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     scrub_enable,
    input  logic                     clear,
    output logic                     memory_request,
    input  logic                     memory_grant,
    output logic                     memory_write,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    output logic [PARITY_WIDTH-1:0]  memory_write_code,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    input  logic [PARITY_WIDTH-1:0]  memory_read_code,
    output logic [COUNT_WIDTH-1:0]   corrected_count,
    output logic [COUNT_WIDTH-1:0]   uncorrectable_count,
    output logic                     uncorrectable_flag,
    output logic [ADDRESS_WIDTH-1:0] uncorrectable_address,
    output logic                     pass_done,
    output logic [2:0]               debug_state
);

    // Hamming check bits sit at power-of-two positions 1,2,4,...; data bits
    // fill the remaining positions in ascending order. The top code bit is
    // the overall parity over all data and Hamming check bits.
    localparam int HAMMING_BITS = PARITY_WIDTH - 1;
    localparam int CODE_LENGTH = DATA_WIDTH + HAMMING_BITS;
    localparam int PERIOD_WIDTH = $clog2(SCRUB_PERIOD + 1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_LAST = PERIOD_WIDTH'(SCRUB_PERIOD - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_LAST = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_READ, S_CAPTURE, S_CHECK, S_WRITE, S_NEXT
    } state_t;

    function automatic logic [CODE_LENGTH:1] place_bits(input logic [DATA_WIDTH-1:0] data,
                                                        input logic [HAMMING_BITS-1:0] check);
        logic [CODE_LENGTH:1] word;
        int d;
        int c;
        word = '0;
        d = 0;
        c = 0;
        for (int p = 1; p <= CODE_LENGTH; p++) begin
            if ((p & (p - 1)) == 0) begin
                word[p] = check[c];
                c++;
            end else begin
                word[p] = data[d];
                d++;
            end
        end
        return word;
    endfunction

    function automatic logic [HAMMING_BITS-1:0] position_syndrome(input logic [CODE_LENGTH:1] word);
        logic [HAMMING_BITS-1:0] s;
        s = '0;
        for (int p = 1; p <= CODE_LENGTH; p++) begin
            for (int i = 0; i < HAMMING_BITS; i++) begin
                if (((p >> i) & 1) == 1) s[i] = s[i] ^ word[p];
            end
        end
        return s;
    endfunction

    function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] data);
        logic [HAMMING_BITS-1:0] h;
        h = position_syndrome(place_bits(data, '0));
        return {(^data) ^ (^h), h};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] correct_data(input logic [DATA_WIDTH-1:0] data,
                                                           input logic [HAMMING_BITS-1:0] syn);
        logic [DATA_WIDTH-1:0] fixed;
        int d;
        fixed = data;
        d = 0;
        for (int p = 1; p <= CODE_LENGTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p == int'(syn)) fixed[d] = ~fixed[d];
                d++;
            end
        end
        return fixed;
    endfunction

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] scrub_address;
    logic [PERIOD_WIDTH-1:0]  period_count;
    logic [DATA_WIDTH-1:0]    captured_data;
    logic [PARITY_WIDTH-1:0]  captured_code;

    logic [HAMMING_BITS-1:0]  syndrome;
    logic                     overall_error;
    logic                     word_single;
    logic                     word_double;
    logic [DATA_WIDTH-1:0]    fixed_data;
    logic [PARITY_WIDTH-1:0]  fixed_code;

    assign memory_address = scrub_address;
    assign debug_state = state;

    // Classify the captured word; an odd error whose syndrome points past the
    // codeword cannot be a single flip and is treated as uncorrectable.
    always_comb begin
        syndrome = position_syndrome(place_bits(captured_data, captured_code[HAMMING_BITS-1:0]));
        overall_error = ^{captured_data, captured_code};
        word_single = overall_error && (int'(syndrome) <= CODE_LENGTH);
        word_double = !word_single && (overall_error || (syndrome != '0));
        fixed_data = correct_data(captured_data, syndrome);
        fixed_code = encode(fixed_data);
    end

    // Scrub sequencer, port handshake and error bookkeeping.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
            scrub_address <= '0;
            period_count <= '0;
            captured_data <= '0;
            captured_code <= '0;
            memory_request <= 1'b0;
            memory_write <= 1'b0;
            memory_write_data <= '0;
            memory_write_code <= '0;
            corrected_count <= '0;
            uncorrectable_count <= '0;
            uncorrectable_flag <= 1'b0;
            uncorrectable_address <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scrub_enable) begin
                        state <= S_WAIT;
                        period_count <= '0;
                    end
                end
                S_WAIT: begin
                    if (!scrub_enable) begin
                        state <= S_IDLE;
                    end else if (period_count == PERIOD_LAST) begin
                        state <= S_READ;
                        memory_request <= 1'b1;
                        memory_write <= 1'b0;
                    end else begin
                        period_count <= period_count + 1'b1;
                    end
                end
                S_READ: begin
                    if (memory_grant) begin
                        memory_request <= 1'b0;
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    captured_data <= memory_read_data;
                    captured_code <= memory_read_code;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (word_single) begin
                        if (corrected_count != '1) corrected_count <= corrected_count + 1'b1;
                        memory_write_data <= fixed_data;
                        memory_write_code <= fixed_code;
                        memory_request <= 1'b1;
                        memory_write <= 1'b1;
                        state <= S_WRITE;
                    end else begin
                        if (word_double) begin
                            if (uncorrectable_count != '1) uncorrectable_count <= uncorrectable_count + 1'b1;
                            if (!uncorrectable_flag) uncorrectable_address <= scrub_address;
                            uncorrectable_flag <= 1'b1;
                        end
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (memory_grant) begin
                        memory_request <= 1'b0;
                        memory_write <= 1'b0;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    scrub_address <= scrub_address + 1'b1;
                    if (scrub_address == ADDRESS_LAST) pass_done <= 1'b1;
                    if (scrub_enable) begin
                        state <= S_WAIT;
                        period_count <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A clear in the same cycle as an increment leaves everything zero.
            if (clear) begin
                corrected_count <= '0;
                uncorrectable_count <= '0;
                uncorrectable_flag <= 1'b0;
                uncorrectable_address <= '0;
            end
        end
    end

endmodule

// File: tb/tb_extended_hamming_scrubber.sv
// Bench for extended_hamming_scrubber: a behavioural memory with fault
// injection answers the scrubber's port, and a model derived from the number
// of flipped bits per word predicts every access and every counter value.

module tb_extended_hamming_scrubber;

    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int AW = 2;
    localparam int PW = 5;     // 4 Hamming bits + overall parity for 8 data bits
    localparam int CW = 2;
    localparam int PERIOD = 4;
    localparam int WORD_BITS = DW + PW;

    logic          clock = 1'b0;
    logic          resetn;
    logic          scrub_enable;
    logic          clear;
    logic          memory_request;
    logic          memory_grant;
    logic          memory_write;
    logic [AW-1:0] memory_address;
    logic [DW-1:0] memory_write_data;
    logic [PW-1:0] memory_write_code;
    logic [DW-1:0] memory_read_data;
    logic [PW-1:0] memory_read_code;
    logic [CW-1:0] corrected_count;
    logic [CW-1:0] uncorrectable_count;
    logic          uncorrectable_flag;
    logic [AW-1:0] uncorrectable_address;
    logic          pass_done;
    logic [2:0]    debug_state;

    extended_hamming_scrubber #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .SCRUB_PERIOD(PERIOD), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .resetn(resetn), .scrub_enable(scrub_enable), .clear(clear),
        .memory_request(memory_request), .memory_grant(memory_grant),
        .memory_write(memory_write), .memory_address(memory_address),
        .memory_write_data(memory_write_data), .memory_write_code(memory_write_code),
        .memory_read_data(memory_read_data), .memory_read_code(memory_read_code),
        .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count),
        .uncorrectable_flag(uncorrectable_flag), .uncorrectable_address(uncorrectable_address),
        .pass_done(pass_done), .debug_state(debug_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference encoder: data bit j lives at the j-th position >= 3 that is
    // not a power of two; check bit i is the XOR of data at positions with bit
    // i set; the top bit makes the parity of the whole word even.
    function automatic logic [PW-1:0] ref_code(input logic [DW-1:0] d);
        logic [PW-1:0] c;
        int p;
        c = '0;
        p = 2;
        for (int j = 0; j < DW; j++) begin
            p++;
            while ((p & (p - 1)) == 0) p++;
            for (int i = 0; i < PW - 1; i++) if (p[i]) c[i] = c[i] ^ d[j];
        end
        c[PW-1] = (^d) ^ (^c[PW-2:0]);
        return c;
    endfunction

    // ---------------- memory and model state ----------------
    logic [DW-1:0] golden   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] mem_code [DEPTH];

    logic [AW+DW+PW-1:0] exp_q[$];   // expected write-back {address, data, code}
    int            exp_addr = 0;
    logic [CW-1:0] corr_model = '0;
    logic [CW-1:0] unc_model = '0;
    logic          flag_model = 1'b0;
    logic [AW-1:0] uaddr_model = '0;
    int            pass_seen = 0;
    int            reads_seen = 0;
    int            writes_seen = 0;
    int            grant_mode = 0;   // 0 always, 1 random, 2 stall 10 cycles, 3 reads only

    int            stall_count = 0;
    logic          deliver = 1'b0;
    logic [AW-1:0] deliver_addr = '0;
    logic          prev_pending = 1'b0;
    logic [1+AW+DW+PW-1:0] prev_snapshot = '0;

    // Memory responder and scoreboard: acts on the falling edge, so every
    // decision here takes effect at the following rising edge.
    always @(negedge clock) begin
        logic g;
        logic [WORD_BITS-1:0] diff;
        int flips;
        int a;
        if (!resetn) begin
            memory_grant = 1'b0;
            deliver = 1'b0;
            prev_pending = 1'b0;
            stall_count = 0;
            exp_q.delete();
            exp_addr = 0;
            corr_model = '0;
            unc_model = '0;
            flag_model = 1'b0;
            uaddr_model = '0;
        end else begin
            if (deliver) begin
                memory_read_data = mem_data[deliver_addr];
                memory_read_code = mem_code[deliver_addr];
                deliver = 1'b0;
            end else begin
                memory_read_data = DW'($urandom_range(0, 255));
                memory_read_code = PW'($urandom_range(0, 31));
            end
            if (prev_pending) begin
                check("request_held", 64'(memory_request), 64'(1));
                if (memory_request)
                    check("request_stable",
                          64'({memory_write, memory_address, memory_write_data, memory_write_code}),
                          64'(prev_snapshot));
            end
            if (pass_done) begin
                pass_seen++;
                check("pass_done_after_last", 64'(exp_addr), 64'(0));
            end
            case (grant_mode)
                0: g = 1'b1;
                1: g = 1'($urandom_range(0, 1));
                2: g = (stall_count >= 10);
                3: g = !memory_write;
                default: g = 1'b1;
            endcase
            memory_grant = g;
            if (memory_request && g) begin
                stall_count = 0;
                a = int'(memory_address);
                if (!memory_write) begin
                    reads_seen++;
                    check("read_address", 64'(memory_address), 64'(exp_addr));
                    check("no_missed_write", 64'(exp_q.size()), 64'(0));
                    exp_q.delete();
                    diff = {mem_code[a] ^ ref_code(golden[a]), mem_data[a] ^ golden[a]};
                    flips = $countones(diff);
                    if (flips == 1) begin
                        exp_q.push_back({memory_address, golden[a], ref_code(golden[a])});
                        if (corr_model != '1) corr_model = corr_model + 1'b1;
                    end else if (flips >= 2) begin
                        if (unc_model != '1) unc_model = unc_model + 1'b1;
                        if (!flag_model) uaddr_model = memory_address;
                        flag_model = 1'b1;
                    end
                    exp_addr = (a + 1) % DEPTH;
                    deliver = 1'b1;
                    deliver_addr = memory_address;
                end else begin
                    writes_seen++;
                    check("write_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0)
                        check("write_word",
                              64'({memory_address, memory_write_data, memory_write_code}),
                              64'(exp_q.pop_front()));
                    mem_data[a] = memory_write_data;
                    mem_code[a] = memory_write_code;
                end
            end else if (memory_request) begin
                stall_count++;
            end
            prev_pending = memory_request && !g;
            prev_snapshot = {memory_write, memory_address, memory_write_data, memory_write_code};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_passes(input int n);
        int target;
        int budget;
        target = pass_seen + n;
        budget = 4000;
        while (pass_seen < target && budget > 0) begin
            step();
            budget--;
        end
        check("pass_timeout", 64'(pass_seen >= target), 64'(1));
    endtask

    task automatic wait_reads(input int target);
        int budget;
        budget = 1000;
        while (reads_seen < target && budget > 0) begin
            step();
            budget--;
        end
        check("read_timeout", 64'(reads_seen >= target), 64'(1));
    endtask

    // Restore word a to its clean encoding, then flip up to two of its bits
    // (index 0..7 data, 8..12 code).
    task automatic inject(input int a, input int n, input int i1, input int i2);
        logic [WORD_BITS-1:0] w;
        w = {ref_code(golden[a]), golden[a]};
        if (n >= 1) w[i1] = ~w[i1];
        if (n >= 2) w[i2] = ~w[i2];
        mem_data[a] = w[DW-1:0];
        mem_code[a] = w[WORD_BITS-1:DW];
    endtask

    task automatic check_status(input string tag);
        check({tag, "_corrected"}, 64'(corrected_count), 64'(corr_model));
        check({tag, "_uncorrectable"}, 64'(uncorrectable_count), 64'(unc_model));
        check({tag, "_flag"}, 64'(uncorrectable_flag), 64'(flag_model));
        check({tag, "_uaddr"}, 64'(uncorrectable_address), 64'(uaddr_model));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        corr_model = '0;
        unc_model = '0;
        flag_model = 1'b0;
        uaddr_model = '0;
        step();
        clear = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a;
        int n;
        int i1;
        resetn = 1'b0;
        scrub_enable = 1'b0;
        clear = 1'b0;
        memory_grant = 1'b0;
        memory_read_data = '0;
        memory_read_code = '0;
        for (int i = 0; i < DEPTH; i++) begin
            golden[i] = DW'($urandom_range(0, 255));
            inject(i, 0, 0, 0);
        end
        repeat (3) @(negedge clock);
        check("reset_request", 64'(memory_request), 64'(0));
        check("reset_write", 64'(memory_write), 64'(0));
        check("reset_address", 64'(memory_address), 64'(0));
        check("reset_state", 64'(debug_state), 64'(0));
        check("reset_pass_done", 64'(pass_done), 64'(0));
        check("reset_write_word", 64'({memory_write_data, memory_write_code}), 64'(0));
        check_status("reset");

        // Clean memory: addresses 0,1,2,3,0 read, nothing written, one pass pulse.
        #2;
        resetn = 1'b1;
        scrub_enable = 1'b1;
        wait_passes(1);
        wait_reads(5);
        check("clean_pass_count", 64'(pass_seen), 64'(1));
        check("clean_writes", 64'(writes_seen), 64'(0));
        check_status("clean");

        // Data bit 5 at address 2: one write-back, then clean on the next pass.
        inject(2, 1, 5, 0);
        wait_passes(1);
        check("data_fix_writes", 64'(writes_seen), 64'(1));
        check("data_fix_corrected", 64'(corrected_count), 64'(1));
        check_status("data_fix");
        wait_passes(1);
        check("data_fix_rescrub_writes", 64'(writes_seen), 64'(1));
        check_status("data_fix_rescrub");

        // Overall parity bit, then Hamming check bit 1, at address 1.
        inject(1, 1, 12, 0);
        wait_passes(1);
        check("overall_fix_writes", 64'(writes_seen), 64'(2));
        check_status("overall_fix");
        inject(1, 1, 9, 0);
        wait_passes(1);
        check("code_fix_writes", 64'(writes_seen), 64'(3));
        check("code_fix_corrected", 64'(corrected_count), 64'(3));
        check_status("code_fix");

        // Two data bits at address 3: counted, flagged, never written back.
        inject(3, 2, 0, 6);
        wait_passes(1);
        check("double_uncorrectable", 64'(uncorrectable_count), 64'(1));
        check("double_uaddr", 64'(uncorrectable_address), 64'(3));
        check_status("double_1");
        wait_passes(1);
        check("double_writes", 64'(writes_seen), 64'(3));
        check_status("double_2");
        pulse_clear();
        check_status("after_clear");
        inject(3, 0, 0, 0);

        // Long grant stalls on both the read and the write-back.
        grant_mode = 2;
        inject(0, 1, 2, 0);
        wait_passes(1);
        check("stall_writes", 64'(writes_seen), 64'(4));
        check_status("stall");

        // Random grants, faults and enable gaps.
        grant_mode = 1;
        for (int pass = 0; pass < 6; pass++) begin
            a = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(0, 2);
            i1 = $urandom_range(0, WORD_BITS - 1);
            inject(a, n, i1, (i1 + 1 + $urandom_range(0, WORD_BITS - 2)) % WORD_BITS);
            if ($urandom_range(0, 2) == 0) begin
                scrub_enable = 1'b0;
                repeat ($urandom_range(2, 6)) step();
                check("disabled_state", 64'(debug_state), 64'(0));
                check("disabled_request", 64'(memory_request), 64'(0));
                scrub_enable = 1'b1;
            end
            wait_passes(1);
            check_status("random");
        end

        // Persistent double error with a 2-bit counter: saturates at 3.
        grant_mode = 0;
        for (int i = 0; i < DEPTH; i++) inject(i, 0, 0, 0);
        pulse_clear();
        inject(3, 2, 1, 10);
        wait_passes(5);
        check("saturated_uncorrectable", 64'(uncorrectable_count), 64'(3));
        check("saturated_corrected", 64'(corrected_count), 64'(0));
        check_status("saturated");

        // Reset while a write-back waits for grant.
        inject(3, 0, 0, 0);
        grant_mode = 3;
        inject(0, 1, 3, 0);
        n = 0;
        while (!(memory_request && memory_write) && n < 500) begin
            step();
            n++;
        end
        check("write_pending_seen", 64'(memory_request && memory_write), 64'(1));
        resetn = 1'b0;
        step();
        check("midreset_request", 64'(memory_request), 64'(0));
        check("midreset_write", 64'(memory_write), 64'(0));
        check("midreset_state", 64'(debug_state), 64'(0));
        check("midreset_address", 64'(memory_address), 64'(0));
        check("midreset_corrected", 64'(corrected_count), 64'(0));
        resetn = 1'b1;
        scrub_enable = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/extended_hamming_scrubber.md
Name: extended_hamming_scrubber

Overview:
Background scrubber for an extended-Hamming-protected memory; sits downstream of the extended Hamming checker/corrector logic on the memory read path. Walks every address at a programmable pace, checks each data+code word, writes back corrected single-bit errors, and records double-bit errors. Shares the memory port with the functional path through a request/grant handshake; the functional path always has priority.

Parameters:
DATA_WIDTH, 8, payload width of each memory word
DEPTH, 16, number of memory words scrubbed; power of two, >= 2
SCRUB_PERIOD, 64, idle cycles between two word scrubs; >= 1
COUNT_WIDTH, 8, width of the saturating error counters
ADDRESS_WIDTH (localparam), $clog2(DEPTH)
PARITY_WIDTH (localparam), `GET_EXTENDED_HAMMING_PARITY_WIDTH(DATA_WIDTH)

Ports:
clock  input  1  clock
resetn  input  1  synchronous active-low reset
scrub_enable  input  1  level; scrubbing runs while high
clear  input  1  pulse; clears counters and sticky flag
memory_request  output  1  scrubber requests the memory port
memory_grant  input  1  port granted this cycle
memory_write  output  1  1 = write access, 0 = read access (valid with request)
memory_address  output  ADDRESS_WIDTH  access address
memory_write_data  output  DATA_WIDTH  corrected data for write-back
memory_write_code  output  PARITY_WIDTH  re-encoded code for write-back
memory_read_data  input  DATA_WIDTH  read data, valid 1 cycle after granted read
memory_read_code  input  PARITY_WIDTH  read code, same timing
corrected_count  output  COUNT_WIDTH  single-bit errors corrected, saturating
uncorrectable_count  output  COUNT_WIDTH  double-bit errors seen, saturating
uncorrectable_flag  output  1  sticky, set on any double-bit error
uncorrectable_address  output  ADDRESS_WIDTH  address of first double-bit error since clear
pass_done  output  1  1-cycle pulse when address DEPTH-1 finishes

Behaviour:
- Reset (resetn low at clock edge): state IDLE, address 0, period counter 0, all outputs 0.
- States: IDLE, WAIT, READ, CAPTURE, CHECK, WRITE, NEXT.
- IDLE: if scrub_enable -> WAIT with period counter cleared.
- WAIT: counts; after SCRUB_PERIOD cycles -> READ. scrub_enable low -> IDLE (address retained).
- READ: memory_request=1, memory_write=0. Stays until memory_grant=1 at an edge -> CAPTURE.
- CAPTURE: registers memory_read_data/code (sampled exactly one cycle after grant) -> CHECK.
- CHECK: syndrome on registered word. No error -> NEXT. Single-bit error (data or code bit, including overall parity bit) -> corrected_count+1, form corrected data and re-encode code -> WRITE. Double-bit error -> uncorrectable_count+1; if flag was 0, latch address; set flag; no write-back -> NEXT.
- WRITE: memory_request=1, memory_write=1, write_data/code held stable until grant -> NEXT.
- NEXT: address+1 mod DEPTH; pulse pass_done when wrapping DEPTH-1 -> 0; -> WAIT if scrub_enable else IDLE.
- scrub_enable falling during READ/CAPTURE/CHECK/WRITE: current word completes (write-back not abandoned); enable only sampled in IDLE, WAIT, NEXT.
- memory_request never drops before grant; address/write/data stable while request high and ungranted.
- Counters saturate at 2^COUNT_WIDTH-1.
- clear: zeroes counters, flag, uncorrectable_address next cycle; does not affect FSM or scrub address. Clear and increment same cycle: clear wins.
- Minimum per-word latency without contention: SCRUB_PERIOD + 4 cycles (clean), +1 cycle for write-back.
- Reset mid-operation: immediate return to IDLE, any pending request dropped.

Test Plan:
- DATA_WIDTH=8, DEPTH=4, clean memory, grant always 1, enable 1 -> reads addresses 0,1,2,3,0; no writes; counters 0; pass_done one pulse after address 3.
- Data bit 5 flipped at address 2 -> one write to address 2 with original data and correct code; corrected_count=1; re-read clean on next pass, count stays 1.
- Code bit flipped (including overall parity) at address 1 -> write-back of correct code, corrected_count=1, flag 0.
- Two data bits flipped at address 3 -> no write; uncorrectable_count=1, flag=1, uncorrectable_address=3; second pass -> count 2, address stays 3; clear -> all zero.
- Grant held low 10 cycles during READ and WRITE -> request, address, write data stable throughout; access completes on grant.
- COUNT_WIDTH=2, persistent double-bit error, 5 passes -> uncorrectable_count saturates at 3; resetn low mid-WRITE -> request drops, state IDLE, address 0.
